// File: rtl/snes_mem_sequencer_if.sv
// SNES / GSU request side and SRAM pin bundle
// for the cart memory sequencer.
interface snes_mem_sequencer_if;
  logic        snes_rd_start;
  logic        snes_wr_start;
  logic        ROM_HIT;
  logic        IS_WRITABLE;
  logic [23:0] ROM_ADDR;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_RDATA;
  logic        snes_rd_done;
  logic        gsu_req;
  logic        gsu_we;
  logic [23:0] gsu_addr;
  logic [7:0]  gsu_wdata;
  logic        gsu_ack;
  logic [7:0]  gsu_rdata;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_DOUT;
  logic [7:0]  MEM_DIN;
  logic        MEM_CE_N;
  logic        MEM_OE_N;
  logic        MEM_WE_N;

  modport slave (
    input  snes_rd_start, snes_wr_start,
    input  ROM_HIT, IS_WRITABLE,
    input  ROM_ADDR, SNES_DATA_IN,
    output SNES_RDATA, snes_rd_done,
    input  gsu_req, gsu_we,
    input  gsu_addr, gsu_wdata,
    output gsu_ack, gsu_rdata,
    output MEM_ADDR, MEM_DOUT,
    input  MEM_DIN,
    output MEM_CE_N, MEM_OE_N, MEM_WE_N
  );

  modport master (
    output snes_rd_start, snes_wr_start,
    output ROM_HIT, IS_WRITABLE,
    output ROM_ADDR, SNES_DATA_IN,
    input  SNES_RDATA, snes_rd_done,
    output gsu_req, gsu_we,
    output gsu_addr, gsu_wdata,
    input  gsu_ack, gsu_rdata,
    input  MEM_ADDR, MEM_DOUT,
    output MEM_DIN,
    input  MEM_CE_N, MEM_OE_N, MEM_WE_N
  );
endinterface

// File: rtl/snes_mem_sequencer.sv
// Shared cart SRAM sequencer: SNES has
// priority, GSU fills idle slots.
module snes_mem_sequencer #(
  parameter int RD_CYCLES = 5,
  parameter int WR_CYCLES = 4
) (
  input logic CLK,
  input logic RST_N,
  snes_mem_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNES_RD,
    S_SNES_WR,
    S_GSU_RD,
    S_GSU_WR
  } state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pv_q, pv_d;
  logic          pwr_q, pwr_d;
  logic [23:0]   paddr_q, paddr_d;
  logic [7:0]    pdata_q, pdata_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          ce_q, ce_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic [7:0]    srd_q, srd_d;
  logic [7:0]    grd_q, grd_d;
  logic          sdone_q, sdone_d;
  logic          gack_q, gack_d;

  logic          s_rd, s_wr, s_pulse;
  logic          op_wr;
  logic          go, go_wr, go_gsu;
  logic [23:0]   go_addr;
  logic [7:0]    go_data;

  // Qualify SNES pulses; a read beats a same-cycle write.
  always_comb begin
    s_rd    = bus.snes_rd_start & bus.ROM_HIT;
    s_wr    = bus.snes_wr_start & bus.IS_WRITABLE & ~s_rd;
    s_pulse = s_rd | s_wr;
    op_wr   = (state_q == S_SNES_WR) || (state_q == S_GSU_WR);
  end

  // Next-state: op selection, wait-state count, pending slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = pv_q;
    pwr_d   = pwr_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    we_d    = we_q;
    srd_d   = srd_q;
    grd_d   = grd_q;
    sdone_d = 1'b0;
    gack_d  = 1'b0;
    go      = 1'b0;
    go_wr   = 1'b0;
    go_gsu  = 1'b0;
    go_addr = '0;
    go_data = '0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          pv_q: begin
            go      = 1'b1;
            go_wr   = pwr_q;
            go_addr = paddr_q;
            go_data = pdata_q;
            pv_d    = 1'b0;
          end
          (!pv_q && s_pulse): begin
            go      = 1'b1;
            go_wr   = s_wr;
            go_addr = bus.ROM_ADDR;
            go_data = bus.SNES_DATA_IN;
          end
          (!pv_q && !s_pulse && bus.gsu_req): begin
            go      = 1'b1;
            go_gsu  = 1'b1;
            go_wr   = bus.gsu_we;
            go_addr = bus.gsu_addr;
            go_data = bus.gsu_wdata;
          end
          default: ;
        endcase
      end
      S_SNES_RD, S_SNES_WR, S_GSU_RD, S_GSU_WR: begin
        if (cnt_q == '0) begin
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          we_d    = 1'b1;
          state_d = S_IDLE;
          if (state_q == S_SNES_RD) begin
            srd_d   = bus.MEM_DIN;
            sdone_d = 1'b1;
          end
          if (state_q == S_GSU_RD) begin
            grd_d  = bus.MEM_DIN;
            gack_d = 1'b1;
          end
          if (state_q == S_GSU_WR) begin
            gack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (op_wr && cnt_q == CW'(1)) begin
            we_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pulse that cannot start now waits in the slot.
    if (s_pulse && (state_q != S_IDLE || pv_q)) begin
      pv_d    = 1'b1;
      pwr_d   = s_wr;
      paddr_d = bus.ROM_ADDR;
      pdata_d = bus.SNES_DATA_IN;
    end

    if (go) begin
      addr_d = go_addr;
      dout_d = go_data;
      ce_d   = 1'b0;
      oe_d   = go_wr;
      we_d   = ~go_wr;
      cnt_d  = go_wr ? WR_LAST : RD_LAST;
      if (go_gsu) begin
        state_d = go_wr ? S_GSU_WR : S_GSU_RD;
      end else begin
        state_d = go_wr ? S_SNES_WR : S_SNES_RD;
      end
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pwr_q   <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      srd_q   <= '0;
      grd_q   <= '0;
      sdone_q <= 1'b0;
      gack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pwr_q   <= pwr_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      srd_q   <= srd_d;
      grd_q   <= grd_d;
      sdone_q <= sdone_d;
      gack_q  <= gack_d;
    end
  end

  assign bus.MEM_ADDR     = addr_q;
  assign bus.MEM_DOUT     = dout_q;
  assign bus.MEM_CE_N     = ce_q;
  assign bus.MEM_OE_N     = oe_q;
  assign bus.MEM_WE_N     = we_q;
  assign bus.SNES_RDATA   = srd_q;
  assign bus.snes_rd_done = sdone_q;
  assign bus.gsu_rdata    = grd_q;
  assign bus.gsu_ack      = gack_q;

endmodule

// File: tb/tb_snes_mem_sequencer.sv
// Bench for snes_mem_sequencer: vector table,
// corner sequences and random traffic vs model.
module tb_snes_mem_sequencer;
  localparam int RD = 5;
  localparam int WR = 4;

  logic CLK = 1'b0;
  logic RST_N;
  snes_mem_sequencer_if bus();

  snes_mem_sequencer #(
    .RD_CYCLES(RD),
    .WR_CYCLES(WR)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: one op record,
  // one pending slot, absolute edge numbers.
  int          ecount = 0;
  bit          m_busy = 0;
  int          m_kind = 0;
  int          m_start = 0;
  logic [23:0] m_addr = '0;
  logic [7:0]  m_dout = '0;
  logic [7:0]  m_srd = '0;
  logic [7:0]  m_grd = '0;
  bit          m_done = 0;
  bit          m_ack = 0;
  bit          p_v = 0;
  bit          p_wr = 0;
  logic [23:0] p_addr = '0;
  logic [7:0]  p_data = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic begin_op(input int k,
                          input logic [23:0] a,
                          input logic [7:0] d);
    m_busy  = 1;
    m_kind  = k;
    m_start = ecount;
    m_addr  = a;
    m_dout  = d;
  endtask

  task automatic model_edge(
    input bit rst_n, input bit rd_s, input bit wr_s,
    input bit hit, input bit wrable,
    input logic [23:0] raddr, input logic [7:0] sdat,
    input bit greq, input bit gwe,
    input logic [23:0] gaddr, input logic [7:0] gwd,
    input logic [7:0] din);
    bit rq, wq, pls;
    int len;
    ecount++;
    m_done = 0;
    m_ack  = 0;
    if (!rst_n) begin
      m_busy = 0; p_v = 0;
      m_addr = '0; m_dout = '0;
      m_srd = '0; m_grd = '0;
      return;
    end
    rq  = rd_s && hit;
    wq  = wr_s && wrable && !rq;
    pls = rq || wq;
    if (m_busy) begin
      len = (m_kind % 2 == 1) ? WR : RD;
      if (ecount - m_start == len) begin
        m_busy = 0;
        if (m_kind == 0) begin m_srd = din; m_done = 1; end
        if (m_kind == 2) begin m_grd = din; m_ack = 1; end
        if (m_kind == 3) m_ack = 1;
      end
      if (pls) begin
        p_v = 1; p_wr = wq; p_addr = raddr; p_data = sdat;
      end
    end else if (p_v) begin
      begin_op(p_wr ? 1 : 0, p_addr, p_data);
      p_v = 0;
      if (pls) begin
        p_v = 1; p_wr = wq; p_addr = raddr; p_data = sdat;
      end
    end else if (pls) begin
      begin_op(wq ? 1 : 0, raddr, sdat);
    end else if (greq) begin
      begin_op(gwe ? 3 : 2, gaddr, gwd);
    end
  endtask

  task automatic step();
    bit r, rs, ws, h, w, gr, gw;
    logic [23:0] ra, ga;
    logic [7:0] sd, gd, di;
    r = RST_N; rs = bus.snes_rd_start; ws = bus.snes_wr_start;
    h = bus.ROM_HIT; w = bus.IS_WRITABLE;
    ra = bus.ROM_ADDR; sd = bus.SNES_DATA_IN;
    gr = bus.gsu_req; gw = bus.gsu_we;
    ga = bus.gsu_addr; gd = bus.gsu_wdata; di = bus.MEM_DIN;
    @(posedge CLK);
    model_edge(r, rs, ws, h, w, ra, sd, gr, gw, ga, gd, di);
    #1;
  endtask

  task automatic check_all();
    bit el_we;
    el_we = m_busy && (m_kind % 2 == 1) &&
            (ecount - m_start < WR - 1);
    chk("ce_n", bus.MEM_CE_N, !m_busy);
    chk("oe_n", bus.MEM_OE_N,
        !(m_busy && (m_kind % 2 == 0)));
    chk("we_n", bus.MEM_WE_N, !el_we);
    chk("mem_addr", bus.MEM_ADDR, m_addr);
    chk("mem_dout", bus.MEM_DOUT, m_dout);
    chk("snes_rdata", bus.SNES_RDATA, m_srd);
    chk("snes_rd_done", bus.snes_rd_done, m_done);
    chk("gsu_rdata", bus.gsu_rdata, m_grd);
    chk("gsu_ack", bus.gsu_ack, m_ack);
  endtask

  task automatic clear_in();
    bus.snes_rd_start = 0; bus.snes_wr_start = 0;
    bus.ROM_HIT = 0; bus.IS_WRITABLE = 0;
    bus.ROM_ADDR = '0; bus.SNES_DATA_IN = '0;
    bus.gsu_req = 0; bus.gsu_we = 0;
    bus.gsu_addr = '0; bus.gsu_wdata = '0;
    bus.MEM_DIN = '0;
  endtask

  task automatic do_reset();
    clear_in();
    RST_N = 0;
    step();
    step();
    RST_N = 1;
  endtask

  typedef struct {
    bit          is_wr;
    bit          qual;
    logic [23:0] addr;
    logic [7:0]  data;
    logic [7:0]  din;
    int          exp_ce;
    int          exp_oe;
    int          exp_we;
    logic [7:0]  exp_rdata;
    int          exp_done;
  } vec_t;

  vec_t vt[6];

  int n_ce, n_oe, n_we, n_dn, n_bad, n_ack;
  int ack_at, st_at, dn_at;

  initial begin
    vt[0] = '{0, 1, 24'h012345, 8'h00, 8'hA5, 5, 5, 0, 8'hA5, 1};
    vt[1] = '{1, 0, 24'hE00010, 8'h3C, 8'h00, 0, 0, 0, 8'hA5, 0};
    vt[2] = '{1, 1, 24'hE00010, 8'h3C, 8'h00, 4, 0, 3, 8'hA5, 0};
    vt[3] = '{0, 0, 24'h000000, 8'h00, 8'h99, 0, 0, 0, 8'hA5, 0};
    vt[4] = '{0, 1, 24'hFFFFFF, 8'h00, 8'h5A, 5, 5, 0, 8'h5A, 1};
    vt[5] = '{1, 1, 24'h000000, 8'hFF, 8'h00, 4, 0, 3, 8'h5A, 0};

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      check_all();
      chk("idle_ce_n", bus.MEM_CE_N, 1'b1);
      chk("idle_rdata", bus.SNES_RDATA, 8'h00);
      chk("idle_ack", bus.gsu_ack | bus.snes_rd_done, 1'b0);
    end

    // Single SNES ops from the vector table.
    for (int v = 0; v < 6; v++) begin
      bus.MEM_DIN = vt[v].din;
      bus.ROM_ADDR = vt[v].addr;
      bus.SNES_DATA_IN = vt[v].data;
      bus.snes_rd_start = !vt[v].is_wr;
      bus.snes_wr_start = vt[v].is_wr;
      bus.ROM_HIT = !vt[v].is_wr && vt[v].qual;
      bus.IS_WRITABLE = vt[v].is_wr && vt[v].qual;
      n_ce = 0; n_oe = 0; n_we = 0; n_dn = 0; n_bad = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (c == 0) begin
          bus.snes_rd_start = 0;
          bus.snes_wr_start = 0;
        end
        check_all();
        if (!bus.MEM_CE_N) begin
          n_ce++;
          if (bus.MEM_ADDR !== vt[v].addr) n_bad++;
          if (vt[v].is_wr && bus.MEM_DOUT !== vt[v].data)
            n_bad++;
        end
        if (!bus.MEM_OE_N) n_oe++;
        if (!bus.MEM_WE_N) n_we++;
        if (bus.snes_rd_done) n_dn++;
      end
      chk($sformatf("vec%0d_ce_cycles", v), n_ce, vt[v].exp_ce);
      chk($sformatf("vec%0d_oe_cycles", v), n_oe, vt[v].exp_oe);
      chk($sformatf("vec%0d_we_cycles", v), n_we, vt[v].exp_we);
      chk($sformatf("vec%0d_done", v), n_dn, vt[v].exp_done);
      chk($sformatf("vec%0d_rdata", v), bus.SNES_RDATA,
          vt[v].exp_rdata);
      chk($sformatf("vec%0d_bus", v), n_bad, 0);
    end

    // GSU read in progress, SNES read arrives in cycle 2.
    do_reset();
    bus.gsu_req = 1; bus.gsu_we = 0;
    bus.gsu_addr = 24'h000100; bus.MEM_DIN = 8'h11;
    step();
    chk("s1_gsu_addr", bus.MEM_ADDR, 24'h000100);
    chk("s1_gsu_oe_n", bus.MEM_OE_N, 1'b0);
    bus.snes_rd_start = 1; bus.ROM_HIT = 1;
    bus.ROM_ADDR = 24'h012345;
    step();
    bus.snes_rd_start = 0;
    ack_at = -1; st_at = -1; dn_at = -1; n_ack = 0;
    for (int e = 2; e <= 16; e++) begin
      step();
      check_all();
      if (bus.gsu_ack) begin
        n_ack++;
        if (ack_at < 0) ack_at = e;
        chk("s1_gsu_rdata", bus.gsu_rdata, 8'h11);
        bus.gsu_req = 0;
        bus.MEM_DIN = 8'h77;
      end
      if (st_at < 0 && !bus.MEM_CE_N &&
          bus.MEM_ADDR == 24'h012345) st_at = e;
      if (bus.snes_rd_done && dn_at < 0) begin
        dn_at = e;
        chk("s1_snes_rdata", bus.SNES_RDATA, 8'h77);
      end
    end
    chk("s1_ack_edge", ack_at, 5);
    chk("s1_snes_start_edge", st_at, 6);
    chk("s1_snes_done_edge", dn_at, 11);
    chk("s1_ack_count", n_ack, 1);

    // GSU request and SNES read in the same idle cycle.
    do_reset();
    bus.gsu_req = 1; bus.gsu_we = 0;
    bus.gsu_addr = 24'h000200; bus.MEM_DIN = 8'h42;
    bus.snes_rd_start = 1; bus.ROM_HIT = 1;
    bus.ROM_ADDR = 24'h012345;
    step();
    bus.snes_rd_start = 0;
    chk("s2_snes_first", bus.MEM_ADDR, 24'h012345);
    ack_at = -1; st_at = -1; dn_at = -1; n_ack = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      check_all();
      if (bus.gsu_ack) begin
        n_ack++;
        if (ack_at < 0) ack_at = e;
        bus.gsu_req = 0;
      end
      if (st_at < 0 && !bus.MEM_CE_N &&
          bus.MEM_ADDR == 24'h000200) st_at = e;
      if (bus.snes_rd_done && dn_at < 0) dn_at = e;
    end
    chk("s2_snes_done_edge", dn_at, 5);
    chk("s2_gsu_start_edge", st_at, 6);
    chk("s2_gsu_ack_edge", ack_at, 11);
    chk("s2_ack_count", n_ack, 1);
    chk("s2_snes_rdata", bus.SNES_RDATA, 8'h42);

    // Reset in cycle 2 of a GSU write, then retry.
    do_reset();
    bus.gsu_req = 1; bus.gsu_we = 1;
    bus.gsu_addr = 24'h000300; bus.gsu_wdata = 8'h5A;
    step();
    chk("s3_we_n_start", bus.MEM_WE_N, 1'b0);
    chk("s3_dout_start", bus.MEM_DOUT, 8'h5A);
    RST_N = 0; bus.gsu_req = 0;
    step();
    chk("s3_rst_ce_n", bus.MEM_CE_N, 1'b1);
    chk("s3_rst_we_n", bus.MEM_WE_N, 1'b1);
    chk("s3_rst_addr", bus.MEM_ADDR, 24'h0);
    chk("s3_rst_dout", bus.MEM_DOUT, 8'h0);
    RST_N = 1;
    n_ack = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      check_all();
      if (bus.gsu_ack) n_ack++;
    end
    chk("s3_no_ack_after_rst", n_ack, 0);
    bus.gsu_req = 1;
    n_ce = 0; n_we = 0; n_ack = 0; n_bad = 0;
    for (int e = 0; e < 15; e++) begin
      step();
      check_all();
      if (!bus.MEM_CE_N) begin
        n_ce++;
        if (bus.MEM_ADDR !== 24'h000300) n_bad++;
      end
      if (!bus.MEM_WE_N) n_we++;
      if (bus.gsu_ack) begin
        n_ack++;
        bus.gsu_req = 0;
      end
    end
    chk("s3_retry_ce_cycles", n_ce, 4);
    chk("s3_retry_we_cycles", n_we, 3);
    chk("s3_retry_acks", n_ack, 1);
    chk("s3_retry_addr", n_bad, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST_N = ($urandom_range(399) != 0);
      bus.snes_rd_start = ($urandom_range(7) == 0);
      bus.snes_wr_start = ($urandom_range(7) == 0);
      bus.ROM_HIT = $urandom_range(1);
      bus.IS_WRITABLE = $urandom_range(1);
      bus.ROM_ADDR = 24'($urandom);
      bus.SNES_DATA_IN = 8'($urandom);
      bus.MEM_DIN = 8'($urandom);
      step();
      check_all();
      if (bus.gsu_ack) begin
        bus.gsu_req = 0;
      end else if (!bus.gsu_req &&
                   $urandom_range(3) == 0) begin
        bus.gsu_req = 1;
        bus.gsu_we = $urandom_range(1);
        bus.gsu_addr = 24'($urandom);
        bus.gsu_wdata = 8'($urandom);
      end else if (bus.gsu_req &&
                   $urandom_range(59) == 0) begin
        bus.gsu_req = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
